// File: rtl/fix_pkg.sv
// Shared types and byte constants for the FIX tag=value field parser.
package fix_pkg;

   typedef enum logic [1:0] {
      S_TAG,
      S_VALUE,
      S_ERR
   } state_e;

   localparam logic [7:0]  SOH          = 8'h01;
   localparam logic [7:0]  EQ           = 8'h3D;
   localparam logic [7:0]  ASCII_0      = 8'h30;
   localparam logic [7:0]  ASCII_9      = 8'h39;
   localparam int unsigned CKSUM_TAG    = 10;
   localparam int unsigned CKSUM_DIGITS = 3;
   localparam int unsigned CKSUM_W      = 10;

endpackage

// File: rtl/fix_dec_acc.sv
// Decimal digit accumulator: value = value*10 + digit, with a digit count that
// stops accepting once MAX_DIGITS have been taken. clr has priority over add.
module fix_dec_acc #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned MAX_DIGITS = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             add,
   input  logic [3:0]       digit,
   output logic [WIDTH-1:0] value,
   output logic             empty,
   output logic             full
);

   localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

   logic [WIDTH-1:0] value_q, value_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign full  = (cnt_q == CNT_W'(MAX_DIGITS));
   assign empty = (cnt_q == '0);
   assign value = value_q;

   always_comb begin
      value_d = value_q;
      cnt_d   = cnt_q;
      if (clr) begin
         value_d = '0;
         cnt_d   = '0;
      end else if (add && !full) begin
         // Product truncates to WIDTH, so arithmetic wraps modulo 2^WIDTH.
         value_d = value_q * WIDTH'(10) + WIDTH'(digit);
         cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '0;
         cnt_q   <= '0;
      end else begin
         value_q <= value_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/fix_field_parser.sv
// Streaming FIX tag=value<SOH> field parser with registered delimiter markers.
// Define FIX_CHECKSUM_EN to add the tag-10 running-sum checksum check.
module fix_field_parser
   import fix_pkg::*;
#(
   parameter int unsigned TAG_W          = 16,
   parameter int unsigned MAX_TAG_DIGITS = 5,
   parameter int unsigned LEN_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctrl,
   input  logic [7:0]       data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [7:0]       data_o,
   output logic             valid_o,
   output logic             tag_s_o,
   output logic             tag_e_o,
   output logic             value_s_o,
   output logic             value_e_o,
   output logic             field_o,
   output logic [TAG_W-1:0] tag_o,
   output logic [LEN_W-1:0] len_o,
   output logic             err_o,
   output logic             cksum_err_o
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             tag_s_q, tag_s_d, tag_e_q, tag_e_d;
   logic             value_s_q, value_s_d, value_e_q, value_e_d;
   logic             field_q, field_d, err_q, err_d;
   logic [TAG_W-1:0] tag_out_q, tag_out_d;
   logic [LEN_W-1:0] len_out_q, len_out_d;

   logic             acc_clr, tag_add, tag_empty, tag_full;
   logic [TAG_W-1:0] tag_val;
   logic             is_digit;

   assign ready_o   = ctrl & rst;
   assign is_digit  = (data_i >= ASCII_0) && (data_i <= ASCII_9);

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign tag_s_o   = tag_s_q;
   assign tag_e_o   = tag_e_q;
   assign value_s_o = value_s_q;
   assign value_e_o = value_e_q;
   assign field_o   = field_q;
   assign err_o     = err_q;
   assign tag_o     = tag_out_q;
   assign len_o     = len_out_q;

   fix_dec_acc #(
      .WIDTH      (TAG_W),
      .MAX_DIGITS (MAX_TAG_DIGITS)
   ) u_tag_acc (
      .clk   (clk),
      .rst   (rst),
      .clr   (acc_clr),
      .add   (tag_add),
      .digit (data_i[3:0]),
      .value (tag_val),
      .empty (tag_empty),
      .full  (tag_full)
   );

`ifdef FIX_CHECKSUM_EN
   logic [7:0]         sum_q, sum_d, snap_q, snap_d;
   logic               bad_q, bad_d, cks_q, cks_d;
   logic               cks_add, cks_full, cks_empty;
   logic [CKSUM_W-1:0] cks_val;
   logic               is_cks_field;

   assign is_cks_field = (tag_val == TAG_W'(CKSUM_TAG));
   assign cksum_err_o  = cks_q;

   fix_dec_acc #(
      .WIDTH      (CKSUM_W),
      .MAX_DIGITS (CKSUM_DIGITS)
   ) u_cks_acc (
      .clk   (clk),
      .rst   (rst),
      .clr   (acc_clr),
      .add   (cks_add),
      .digit (data_i[3:0]),
      .value (cks_val),
      .empty (cks_empty),
      .full  (cks_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q  <= '0;
         snap_q <= '0;
         bad_q  <= 1'b0;
         cks_q  <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         snap_q <= snap_d;
         bad_q  <= bad_d;
         cks_q  <= cks_d;
      end
   end
`else
   assign cksum_err_o = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      tag_s_d   = 1'b0;
      tag_e_d   = 1'b0;
      value_s_d = 1'b0;
      value_e_d = 1'b0;
      field_d   = 1'b0;
      err_d     = 1'b0;
      tag_out_d = tag_out_q;
      len_out_d = len_out_q;
      acc_clr   = 1'b0;
      tag_add   = 1'b0;
`ifdef FIX_CHECKSUM_EN
      sum_d   = sum_q;
      snap_d  = snap_q;
      bad_d   = bad_q;
      cks_d   = 1'b0;
      cks_add = 1'b0;
`endif
      if (!ctrl) begin
         // Disabled parser: drop whatever field was in flight.
         state_d = S_TAG;
         len_d   = '0;
         acc_clr = 1'b1;
`ifdef FIX_CHECKSUM_EN
         sum_d = '0;
`endif
      end else if (valid_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
`ifdef FIX_CHECKSUM_EN
         sum_d = sum_q + data_i;
`endif
         unique case (state_q)
            S_TAG: begin
               if (is_digit && !tag_full) begin
                  tag_add = 1'b1;
                  if (tag_empty) begin
                     tag_s_d = 1'b1;
`ifdef FIX_CHECKSUM_EN
                     snap_d = sum_q;
`endif
                  end
               end else if (data_i == EQ && !tag_empty) begin
                  tag_e_d = 1'b1;
                  state_d = S_VALUE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
                  acc_clr = 1'b1;
               end
            end
            S_VALUE: begin
               if (data_i == SOH) begin
                  acc_clr = 1'b1;
                  len_d   = '0;
                  if (len_q == '0) begin
                     err_d   = 1'b1;
                     state_d = S_ERR;
                  end else begin
                     value_e_d = 1'b1;
                     field_d   = 1'b1;
                     tag_out_d = tag_val;
                     len_out_d = len_q;
                     state_d   = S_TAG;
`ifdef FIX_CHECKSUM_EN
                     if (is_cks_field) begin
                        cks_d = bad_q || cks_empty || (cks_val != {2'b00, snap_q});
                        sum_d = '0;
                     end
`endif
                  end
               end else begin
                  if (len_q != '1) len_d = len_q + 1'b1;
                  if (len_q == '0) value_s_d = 1'b1;
`ifdef FIX_CHECKSUM_EN
                  if (is_cks_field) begin
                     if (is_digit && !cks_full) cks_add = 1'b1;
                     else                       bad_d   = 1'b1;
                  end
`endif
               end
            end
            S_ERR: begin
               if (data_i == SOH) state_d = S_TAG;
            end
            default: state_d = S_TAG;
         endcase
      end
`ifdef FIX_CHECKSUM_EN
      if (acc_clr) bad_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_TAG;
         len_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         tag_s_q   <= 1'b0;
         tag_e_q   <= 1'b0;
         value_s_q <= 1'b0;
         value_e_q <= 1'b0;
         field_q   <= 1'b0;
         err_q     <= 1'b0;
         tag_out_q <= '0;
         len_out_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         tag_s_q   <= tag_s_d;
         tag_e_q   <= tag_e_d;
         value_s_q <= value_s_d;
         value_e_q <= value_e_d;
         field_q   <= field_d;
         err_q     <= err_d;
         tag_out_q <= tag_out_d;
         len_out_q <= len_out_d;
      end
   end

endmodule

// File: tb/tb_fix_field_parser.sv
// Directed bench for fix_field_parser with an expected-output scoreboard.
module tb_fix_field_parser;

   logic        clk = 1'b0;
   logic        rst, ctrl, valid_i, ready_o, valid_o;
   logic [7:0]  data_i, data_o;
   logic        tag_s_o, tag_e_o, value_s_o, value_e_o, field_o, err_o, cksum_err_o;
   logic [15:0] tag_o;
   logic [7:0]  len_o;

   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] TS   = 7'b1000000;
   localparam logic [6:0] TE   = 7'b0100000;
   localparam logic [6:0] VS   = 7'b0010000;
   localparam logic [6:0] VE   = 7'b0001000;
   localparam logic [6:0] FD   = 7'b0000100;
   localparam logic [6:0] ER   = 7'b0000010;
   localparam logic [6:0] CK   = 7'b0000001;

   typedef struct {
      logic [7:0]  data;
      logic [6:0]  flags;
      logic [15:0] tag;
      logic [7:0]  len;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fix_field_parser #(
      .TAG_W          (16),
      .MAX_TAG_DIGITS (5),
      .LEN_W          (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ctrl        (ctrl),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .tag_s_o     (tag_s_o),
      .tag_e_o     (tag_e_o),
      .value_s_o   (value_s_o),
      .value_e_o   (value_e_o),
      .field_o     (field_o),
      .tag_o       (tag_o),
      .len_o       (len_o),
      .err_o       (err_o),
      .cksum_err_o (cksum_err_o)
   );

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic logic [6:0] pulses();
      return {tag_s_o, tag_e_o, value_s_o, value_e_o, field_o, err_o, cksum_err_o};
   endfunction

   // Drive one byte; its expected output is queued at drive time.
   task automatic send(input logic [7:0] b, input logic [6:0] f, input logic [15:0] t,
                       input logic [7:0] l);
      exp_t e;
      @(negedge clk);
      e.data = b; e.flags = f; e.tag = t; e.len = l;
      sb.push_back(e);
      data_i  = b;
      valid_i = 1'b1;
      @(posedge clk);
      #1 valid_i = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (valid_o) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'(valid_o), 32'd0);
         end else begin
            e = sb.pop_front();
            check("data_o", 32'(data_o), 32'(e.data));
            check("pulses", 32'(pulses()), 32'(e.flags));
            if (e.flags[2]) begin
               check("tag_o", 32'(tag_o), 32'(e.tag));
               check("len_o", 32'(len_o), 32'(e.len));
            end
         end
      end else begin
         check("idle_pulses", 32'(pulses()), 32'd0);
      end
   end

   initial begin
      rst = 1'b0; ctrl = 1'b1; valid_i = 1'b0; data_i = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_data", 32'(data_o), 32'd0);
      check("rst_tag", 32'(tag_o), 32'd0);
      check("rst_len", 32'(len_o), 32'd0);
      #1 rst = 1'b1;
      #1 check("ready_eq_ctrl", 32'(ready_o), 32'd1);

      // "39=CIC|"
      send(8'h33, TS, 0, 0); send(8'h39, NONE, 0, 0); send(8'h3D, TE, 0, 0);
      send(8'h43, VS, 0, 0); send(8'h49, NONE, 0, 0); send(8'h43, NONE, 0, 0);
      send(8'h01, VE | FD, 16'd39, 8'd3);

      // "3A=X|" then "8=A|"
      send(8'h33, TS, 0, 0); send(8'h41, ER, 0, 0); send(8'h3D, NONE, 0, 0);
      send(8'h58, NONE, 0, 0); send(8'h01, NONE, 0, 0);
      send(8'h38, TS, 0, 0); send(8'h3D, TE, 0, 0); send(8'h41, VS, 0, 0);
      send(8'h01, VE | FD, 16'd8, 8'd1);

      // "35=|" errors on SOH; a bare SOH then resynchronises
      send(8'h33, TS, 0, 0); send(8'h35, NONE, 0, 0); send(8'h3D, TE, 0, 0);
      send(8'h01, ER, 0, 0);
      send(8'h01, NONE, 0, 0);

      // "123456=X|": sixth digit is one too many
      send(8'h31, TS, 0, 0);
      for (int i = 2; i <= 5; i++) send(8'h30 + 8'(i), NONE, 0, 0);
      send(8'h36, ER, 0, 0); send(8'h3D, NONE, 0, 0); send(8'h58, NONE, 0, 0);
      send(8'h01, NONE, 0, 0);

      // "99999=Z|": five digits accepted, tag wraps to 99999 mod 65536
      send(8'h39, TS, 0, 0);
      for (int i = 0; i < 4; i++) send(8'h39, NONE, 0, 0);
      send(8'h3D, TE, 0, 0); send(8'h5A, VS, 0, 0);
      send(8'h01, VE | FD, 16'd34463, 8'd1);

      // "5=" + 300 bytes: length saturates at 255
      send(8'h35, TS, 0, 0); send(8'h3D, TE, 0, 0);
      for (int i = 0; i < 300; i++) send(8'h41, (i == 0) ? VS : NONE, 0, 0);
      send(8'h01, VE | FD, 16'd5, 8'd255);

      // Reset mid-field after "35=A", then "8=B|"
      send(8'h33, TS, 0, 0); send(8'h35, NONE, 0, 0); send(8'h3D, TE, 0, 0);
      send(8'h41, VS, 0, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mid_field", 32'(field_o), 32'd0);
      check("rst_mid_len", 32'(len_o), 32'd0);
      check("rst_mid_sb", 32'(sb.size()), 32'd0);
      #1 rst = 1'b1;
      send(8'h38, TS, 0, 0); send(8'h3D, TE, 0, 0); send(8'h42, VS, 0, 0);
      send(8'h01, VE | FD, 16'd8, 8'd1);

      // ctrl=0 mid-value: bytes are refused and the field is dropped
      send(8'h37, TS, 0, 0); send(8'h3D, TE, 0, 0); send(8'h41, VS, 0, 0);
      send(8'h42, NONE, 0, 0);
      @(negedge clk);
      #1 ctrl = 1'b0; data_i = 8'h01; valid_i = 1'b1;
      #1 check("ctrl_ready", 32'(ready_o), 32'd0);
      repeat (3) @(negedge clk);
      #1 valid_i = 1'b0; ctrl = 1'b1;
      send(8'h39, TS, 0, 0); send(8'h3D, TE, 0, 0); send(8'h5A, VS, 0, 0);
      send(8'h01, VE | FD, 16'd9, 8'd1);

`ifdef FIX_CHECKSUM_EN
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         // "8=A|" sums to 183; then "10=183|" matches, "10=184|" does not
         send(8'h38, TS, 0, 0); send(8'h3D, TE, 0, 0); send(8'h41, VS, 0, 0);
         send(8'h01, VE | FD, 16'd8, 8'd1);
         send(8'h31, TS, 0, 0); send(8'h30, NONE, 0, 0); send(8'h3D, TE, 0, 0);
         send(8'h31, VS, 0, 0); send(8'h38, NONE, 0, 0);
         send((k == 0) ? 8'h33 : 8'h34, NONE, 0, 0);
         send(8'h01, (k == 0) ? (VE | FD) : (VE | FD | CK), 16'd10, 8'd3);
      end
`endif

      repeat (5) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fix_field_parser.md
FIX_FIELD_PARSER -- requirements
Module: fix_field_parser

Interface
REQ-001 SHALL have parameter TAG_W, default 16, width of decoded tag number.
REQ-002 SHALL have parameter MAX_TAG_DIGITS, default 5, maximum ASCII digits in a tag.
REQ-003 SHALL have parameter LEN_W, default 8, width of value-length counter.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ctrl  input  1  parser enable; 0 flushes to S_TAG and deasserts ready_o.
REQ-007 SHALL have port data_i  input  8  FIX byte stream.
REQ-008 SHALL have port valid_i  input  1  data_i valid.
REQ-009 SHALL have port ready_o  output  1  byte accepted when valid_i & ready_o; equals ctrl.
REQ-010 SHALL have port data_o  output  8  registered echo of accepted byte.
REQ-011 SHALL have port valid_o  output  1  data_o valid.
REQ-012 SHALL have ports tag_s_o, tag_e_o, value_s_o, value_e_o  output  1 each  one-cycle delimiter markers aligned with data_o.
REQ-013 SHALL have port field_o  output  1  one-cycle pulse, completed field; tag_o and len_o are valid.
REQ-014 SHALL have port tag_o  output  TAG_W  decoded binary tag.
REQ-015 SHALL have port len_o  output  LEN_W  value byte count, saturating.
REQ-016 SHALL have port err_o  output  1  one-cycle syntax-error pulse.
REQ-017 SHALL have port cksum_err_o  output  1  one-cycle checksum-mismatch pulse.

Function
REQ-018 SHALL implement states S_TAG, S_VALUE and S_ERR; all outputs registered; latency one cycle from accept to output.
REQ-019 In S_TAG, digit '0'-'9': tag = tag*10 + digit; first digit of a field drives tag_s_o.
REQ-020 In S_TAG, '=' with 1..MAX_TAG_DIGITS digits: tag_e_o, go to S_VALUE; '=' with zero digits: err_o, go to S_ERR.
REQ-021 In S_TAG, any other byte, or a digit beyond MAX_TAG_DIGITS: err_o, go to S_ERR; tag arithmetic truncates to TAG_W.
REQ-022 In S_VALUE, a non-SOH byte increments len; the first such byte drives value_s_o; len saturates at 2^LEN_W-1.
REQ-023 In S_VALUE, SOH (0x01) with len>0: value_e_o and field_o, go to S_TAG; SOH with len==0: err_o, go to S_ERR.
REQ-024 In S_ERR, discard bytes (valid_o still echoes) until SOH, then go to S_TAG with no marker.
REQ-025 ctrl falling: state to S_TAG, accumulators cleared, in-flight field dropped with no field_o.
REQ-026 Cycles with no accept: valid_o and all pulses 0; tag_o and len_o hold.

Reset
REQ-027 While rst==0, all outputs SHALL be 0, state S_TAG, and accumulators and checksum SHALL be 0; assertion mid-field discards the field.

Configuration
REQ-028 Macro FIX_CHECKSUM_EN SHALL, when defined, add a mod-256 running sum of accepted bytes, snapshot at each field's first tag digit.
REQ-029 With FIX_CHECKSUM_EN defined, when a tag-10 field completes, its decimal value SHALL be compared with the snapshot: mismatch or non-digit value pulses cksum_err_o with field_o, and the running sum then clears.
REQ-030 Without FIX_CHECKSUM_EN, cksum_err_o SHALL be tied 0 and no sum logic SHALL exist.

Structure
REQ-031 Package fix_pkg SHALL hold the state enum and constants SOH=8'h01, EQ=8'h3D, ASCII_0=8'h30, CKSUM_TAG=10.
REQ-032 Sub-module fix_dec_acc SHALL be a parametrised decimal digit accumulator with digit count, used for the tag and the checksum value.

Verification
REQ-033 Bytes 33 39 3D 43 49 43 01 ("39=CIC|") -> tag_s_o, tag_e_o, value_s_o, value_e_o in order; field_o with tag_o=39, len_o=3.
REQ-034 "3A=X|" -> err_o on 'A', no field_o; following "8=A|" -> field_o with tag_o=8.
REQ-035 "35=|" -> err_o on SOH; "123456=X|" with MAX_TAG_DIGITS=5 -> err_o on the sixth digit.
REQ-036 With FIX_CHECKSUM_EN: "8=A|10=183|" -> cksum_err_o stays 0; "8=A|10=184|" -> cksum_err_o pulses with the second field_o.
REQ-037 rst low after "35=A" then "8=B|" -> no field for tag 35; field_o with tag_o=8, len_o=1; ctrl=0 mid-value -> ready_o=0 and no field_o.
